// File: rtl/router_local_ni_if.sv
// Interface bundle for the router local-port network interface.
// Groups the tile-side handshakes, the router-side req/ack links and the
// status flags; clock and reset stay plain ports on the module.
interface router_local_ni_if #(
  parameter int DATA_W = 32
);
  // Tile inject side
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] tx_flit;
  // Tile eject side
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] rx_flit;
  // Router local input (inject direction)
  logic              net_req_out;
  logic [DATA_W-1:0] net_flit_out;
  logic              net_ack_in;
  // Router local output (eject direction)
  logic              net_req_in;
  logic [DATA_W-1:0] net_flit_in;
  logic              net_ack_out;
  // Status
  logic              tx_stalled;
  logic              rx_overflow;
  logic [7:0]        rx_drop_cnt;

  // Network interface view
  modport slave (
    input  tx_valid, tx_flit, rx_ready, net_ack_in, net_req_in, net_flit_in,
    output tx_ready, rx_valid, rx_flit, net_req_out, net_flit_out, net_ack_out,
           tx_stalled, rx_overflow, rx_drop_cnt
  );

  // Tile plus router view
  modport master (
    output tx_valid, tx_flit, rx_ready, net_ack_in, net_req_in, net_flit_in,
    input  tx_ready, rx_valid, rx_flit, net_req_out, net_flit_out, net_ack_out,
           tx_stalled, rx_overflow, rx_drop_cnt
  );
endinterface

// File: rtl/router_local_ni.sv
// Local-port network interface: an inject FIFO drained by a SEND/WAIT
// retry FSM toward the router, and an eject FIFO that captures every flit
// the router pushes out, dropping and counting flits when it is full.
module router_local_ni #(
  parameter int DATA_W      = 32,
  parameter int TX_DEPTH    = 4,
  parameter int RX_DEPTH    = 4,
  parameter int RETRY_LIMIT = 15
) (
  input logic               clk,
  input logic               rst_n,
  router_local_ni_if.slave  bus
);

  localparam int TPW = $clog2(TX_DEPTH);
  localparam int TCW = TPW + 1;
  localparam int RPW = $clog2(RX_DEPTH);
  localparam int RCW = RPW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // ---------------- inject side ----------------
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [TPW-1:0]    tx_wr_ptr_q, tx_rd_ptr_q;
  logic [TCW-1:0]    tx_cnt_q, tx_cnt_d;
  logic              tx_full, tx_empty, tx_push, tx_pop;

  state_e            state_q, state_d;
  logic [7:0]        retry_q, retry_d;
  logic              net_req;

  assign tx_full  = (tx_cnt_q == TCW'(TX_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_push  = bus.tx_valid && !tx_full;

  assign bus.tx_ready     = !tx_full;
  assign bus.net_req_out  = net_req;
  assign bus.net_flit_out = tx_mem[tx_rd_ptr_q];
  assign bus.tx_stalled   = (retry_q >= 8'(RETRY_LIMIT));

  // Inject storage write; payload is not reset
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= bus.tx_flit;
  end

  // Inject occupancy: simultaneous push and pop leave the count unchanged
  always_comb begin
    tx_cnt_d = tx_cnt_q + TCW'(tx_push) - TCW'(tx_pop);
  end

  // Inject pointers and count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_cnt_q    <= '0;
    end else begin
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + TPW'(1);
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + TPW'(1);
      tx_cnt_q <= tx_cnt_d;
    end
  end

  // Inject FSM next state: one-cycle req, then wait for the registered ack
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    net_req = 1'b0;
    tx_pop  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!tx_empty) state_d = ST_SEND;
      end
      ST_SEND: begin
        net_req = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.net_ack_in) begin
          tx_pop  = 1'b1;
          retry_d = 8'd0;
          // Decided on pre-edge occupancy; a same-cycle push is picked up from IDLE
          state_d = (tx_cnt_q > TCW'(1)) ? ST_SEND : ST_IDLE;
        end else begin
          retry_d = sat_inc8(retry_q);
          state_d = ST_SEND;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Inject FSM state and retry counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      retry_q <= 8'd0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
    end
  end

  // ---------------- eject side ----------------
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [RPW-1:0]    rx_wr_ptr_q, rx_rd_ptr_q;
  logic [RCW-1:0]    rx_cnt_q, rx_cnt_d;
  logic              rx_full, rx_empty, rx_push, rx_pop, rx_drop;
  logic              ack_q, ovf_q;
  logic [7:0]        drop_q;

  assign rx_full  = (rx_cnt_q == RCW'(RX_DEPTH));
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_push  = bus.net_req_in && !rx_full;
  assign rx_drop  = bus.net_req_in && rx_full;
  assign rx_pop   = !rx_empty && bus.rx_ready;

  assign bus.rx_valid    = !rx_empty;
  assign bus.rx_flit     = rx_mem[rx_rd_ptr_q];
  assign bus.net_ack_out = ack_q;
  assign bus.rx_overflow = ovf_q;
  assign bus.rx_drop_cnt = drop_q;

  // Eject storage write; payload is not reset
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr_q] <= bus.net_flit_in;
  end

  // Eject occupancy: a pop never makes room for a push into a full FIFO
  always_comb begin
    rx_cnt_d = rx_cnt_q + RCW'(rx_push) - RCW'(rx_pop);
  end

  // Eject pointers, count, capture ack and drop accounting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_cnt_q    <= '0;
      ack_q       <= 1'b0;
      ovf_q       <= 1'b0;
      drop_q      <= 8'd0;
    end else begin
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + RPW'(1);
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + RPW'(1);
      rx_cnt_q <= rx_cnt_d;
      ack_q    <= rx_push;
      if (rx_drop) begin
        ovf_q  <= 1'b1;
        drop_q <= sat_inc8(drop_q);
      end
    end
  end

endmodule
